store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Store-path companion to the datapath's immediate/load sign extension: it narrows a 32-bit register value to byte, halfword or word width for a store. It replicates the data onto the correct memory byte lanes, generates byte enables, and queues the write in a small FIFO. The FIFO drains to data memory over a req/ack handshake. It sits between the execute stage (store issue) and the data-memory write port.

## Interface
- DEPTH, 2, store-buffer entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept; equals !full
- st_addr  in  32  byte address of the store
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- st_data  in  32  register (rt) value; the low bytes are significant
- mem_req  out  1  head entry valid toward memory
- mem_addr  out  32  word address of the head entry, bits [1:0] = 00
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables; bit i enables bits [8i+7:8i]
- mem_ack  in  1  memory accepted the head entry this cycle
- st_misalign  out  1  one-cycle pulse when a store is rejected
- buf_empty  out  1  no entries queued

## Operation
- **Handshake:** a store is accepted when st_valid && st_ready.
- **Acceptance checks:** an accepted, legal store is enqueued. An accepted, illegal store is dropped, with handling per the Configuration section.
- **Lane mapping (little-endian, a = st_addr[1:0]):**
  - Byte: wdata = {4{st_data[7:0]}}, be = 4'b0001 << a.
  - Half: wdata = {2{st_data[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = st_data, be = 4'b1111.
- **Entry address:** each entry stores mem_addr = {st_addr[31:2], 2'b00}.
- **Illegal store:** halfword with a[0] = 1, word with a ≠ 00, or size 11.
- **FIFO:** circular, with write pointer, read pointer and occupancy count; pointers wrap modulo DEPTH.
  - The head entry is driven on mem_addr/mem_wdata/mem_be.
  - mem_req = !buf_empty.
  - An entry is dequeued on mem_req && mem_ack.
  - mem_ack while mem_req = 0 is ignored.
- **Ordering:** entries retire strictly in acceptance order. There is no merging or forwarding.
- **Simultaneous enqueue and dequeue (not full):** count is unchanged and both pointers advance.
- **When full:** st_ready = 0, even if mem_ack arrives in the same cycle, because st_ready is derived from the registered count.

## Timing
- **Reset values:** while rst is high and after its release:
  - count = 0 and both pointers = 0.
  - All entry storage = 0.
  - mem_req = 0; mem_addr, mem_wdata, mem_be = 0.
  - buf_empty = 1, st_ready = 1, st_misalign = 0.
- **Reset mid-operation:** reset takes effect immediately (asynchronous). All queued stores are discarded and none are written.
- **Enqueue latency:** a store accepted at edge N drives mem_req = 1 after edge N when the buffer was empty, i.e. one cycle of latency.
- **Hold stability:** mem_addr, mem_wdata and mem_be stay stable while mem_req = 1 and mem_ack = 0.
- **Throughput:** one store per cycle with zero-wait memory. With a continuously asserted mem_ack, a DEPTH-full buffer drains in DEPTH cycles.
- **st_misalign:** registered; it pulses for exactly one cycle, the cycle after the illegal store is accepted.
- **No combinational paths:** there is no path from the st_* inputs or from mem_ack to any output.

## Configuration
- **STORE_MISALIGN_TRAP_EN defined:**
  - Illegal stores are accepted (st_ready behaviour is unchanged), not enqueued, and st_misalign pulses.
- **Not defined:**
  - No store is illegal and st_misalign is tied 0.
  - Size 11 is treated as word.
  - A halfword uses lane a[1] and ignores a[0].
  - A word ignores a[1:0].
  - All stores are enqueued.

## Test plan
- **Reset then byte store:** reset, then store byte addr 0x1003, data 0x000000A5 → next cycle mem_req = 1, mem_addr = 0x1000, mem_wdata = 0xA5A5A5A5, mem_be = 1000.
- **Halfword lanes:** store half addr 0x2002, data 0xFFFF1234; ack → mem_wdata = 0x12341234, mem_be = 1100. Then addr 0x2000 → mem_be = 0011.
- **Fill and drain:** DEPTH = 2 with mem_ack = 0; issue 3 word stores 0x10, 0x20, 0x30 → st_ready = 0 after the second. Hold mem_ack = 1 → addresses retire in order 0x10, 0x20; the third is accepted only after st_ready returns to 1.
- **Concurrent accept and ack:** one entry queued; in the same cycle, mem_ack = 1 and a new store → count stays 1, and the new entry appears on the next cycle.
- **Illegal stores:** word store addr 0x3001.
  - With STORE_MISALIGN_TRAP_EN: st_misalign pulses for 1 cycle and buf_empty stays 1.
  - Without it: entry addr 0x3000, be = 1111.
- **Reset mid-operation:** assert rst with 2 entries queued → mem_req = 0 and buf_empty = 1 immediately. After release there is no write until a new store arrives.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a register value to byte/half/word for a store,
// replicates it onto the memory byte lanes, builds byte enables and queues the
// write in a small circular FIFO that drains over a mem_req/mem_ack handshake.
// Optional feature macro: STORE_MISALIGN_TRAP_EN (reject misaligned/reserved
// stores and pulse st_misalign). Without it every store is enqueued.
module store_narrow_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_misalign,
  output logic        buf_empty
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } entry_t;

  entry_t             entries_q [DEPTH];
  entry_t             entries_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             enq_entry;
  logic               legal;
  logic               full;
  logic               accept;
  logic               enq;
  logic               deq;
  entry_t             head;

  // Status derived only from registered occupancy
  assign full      = (count_q == CNT_W'(DEPTH));
  assign buf_empty = (count_q == CNT_W'(0));
  assign st_ready  = ~full;
  assign mem_req   = ~buf_empty;

  // Head entry drives the memory port straight from storage
  assign head      = entries_q[rd_ptr_q];
  assign mem_addr  = head.addr;
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;

  assign accept = st_valid & st_ready;
  assign enq    = accept & legal;
  assign deq    = mem_req & mem_ack;

  // Lane replication, byte enables and legality of the incoming store
  always_comb begin
    enq_entry      = '0;
    legal          = 1'b1;
    enq_entry.addr = {st_addr[31:2], 2'b00};
    case (st_size)
      2'b00: begin
        enq_entry.wdata = {4{st_data[7:0]}};
        enq_entry.be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        enq_entry.wdata = {2{st_data[15:0]}};
        enq_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        enq_entry.wdata = st_data;
        enq_entry.be    = 4'b1111;
      end
    endcase
`ifdef STORE_MISALIGN_TRAP_EN
    case (st_size)
      2'b01:   legal = ~st_addr[0];
      2'b10:   legal = (st_addr[1:0] == 2'b00);
      2'b11:   legal = 1'b0;
      default: legal = 1'b1;
    endcase
`endif
  end

  // FIFO next-state: pointers, occupancy and entry storage
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (enq) begin
      entries_d[wr_ptr_q] = enq_entry;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Flag a rejected store for exactly one cycle
  always_comb begin
    misalign_d = accept & ~legal;
  end

  // Misalign pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign st_misalign = misalign_q;
`else
  assign st_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed self-checking bench for store_narrow_unit (DEPTH = 2).
module tb_store_narrow_unit;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        st_misalign;
  logic        buf_empty;

  int checks = 0;
  int errors = 0;

  store_narrow_unit #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_size    (st_size),
    .st_data    (st_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .st_misalign(st_misalign),
    .buf_empty  (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it if it differs
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one store for a single edge
  task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    step();
    st_valid = 1'b0;
  endtask

  // Acknowledge the head entry for a single edge
  task automatic ack_step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_size  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req",      32'(mem_req),     32'd0);
    chk("rst_empty",    32'(buf_empty),   32'd1);
    chk("rst_ready",    32'(st_ready),    32'd1);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    chk("rst_addr",     mem_addr,         32'h0);
    chk("rst_wdata",    mem_wdata,        32'h0);
    chk("rst_be",       32'(mem_be),      32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_req", 32'(mem_req), 32'd0);

    // Byte store to lane 3
    issue(2'b00, 32'h0000_1003, 32'h0000_00A5);
    chk("byte_req",   32'(mem_req), 32'd1);
    chk("byte_addr",  mem_addr,     32'h0000_1000);
    chk("byte_wdata", mem_wdata,    32'hA5A5_A5A5);
    chk("byte_be",    32'(mem_be),  32'h8);
    ack_step();
    chk("byte_drained", 32'(buf_empty), 32'd1);
    chk("byte_req_off", 32'(mem_req),   32'd0);

    // Halfword lanes, upper then lower
    issue(2'b01, 32'h0000_2002, 32'hFFFF_1234);
    chk("half_hi_wdata", mem_wdata,   32'h1234_1234);
    chk("half_hi_be",    32'(mem_be), 32'hC);
    chk("half_hi_addr",  mem_addr,    32'h0000_2000);
    ack_step();
    issue(2'b01, 32'h0000_2000, 32'hFFFF_1234);
    chk("half_lo_be",    32'(mem_be), 32'h3);
    chk("half_lo_wdata", mem_wdata,   32'h1234_1234);
    ack_step();

    // Byte lane 1 and an aligned word queued back to back
    issue(2'b00, 32'h0000_0005, 32'h1234_56C3);
    issue(2'b10, 32'h0000_0008, 32'hDEAD_BEEF);
    chk("b1_wdata", mem_wdata,   32'hC3C3_C3C3);
    chk("b1_be",    32'(mem_be), 32'h2);
    ack_step();
    chk("word_addr",  mem_addr,    32'h0000_0008);
    chk("word_wdata", mem_wdata,   32'hDEAD_BEEF);
    chk("word_be",    32'(mem_be), 32'hF);
    ack_step();
    chk("pair_drained", 32'(buf_empty), 32'd1);

    // Fill to DEPTH, stall, then drain with ack held high
    issue(2'b10, 32'h0000_0010, 32'h0000_0001);
    chk("fill1_ready", 32'(st_ready), 32'd1);
    issue(2'b10, 32'h0000_0020, 32'h0000_0002);
    chk("fill2_ready", 32'(st_ready), 32'd0);
    chk("fill2_head",  mem_addr,      32'h0000_0010);
    st_valid = 1'b1;
    st_size  = 2'b10;
    st_addr  = 32'h0000_0030;
    st_data  = 32'h0000_0003;
    step();
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("hold_addr",  mem_addr,      32'h0000_0010);
    chk("hold_wdata", mem_wdata,     32'h0000_0001);
    mem_ack = 1'b1;
    step();
    chk("drain1_addr",  mem_addr,      32'h0000_0020);
    chk("drain1_ready", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    chk("drain2_addr", mem_addr,     32'h0000_0030);
    chk("drain2_req",  32'(mem_req), 32'd1);
    step();
    mem_ack = 1'b0;
    chk("drain_empty", 32'(buf_empty), 32'd1);

    // Concurrent accept and ack with one entry queued
    issue(2'b10, 32'h0000_0040, 32'h0000_0004);
    st_valid = 1'b1;
    st_size  = 2'b10;
    st_addr  = 32'h0000_0050;
    st_data  = 32'h0000_0005;
    mem_ack  = 1'b1;
    step();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    chk("conc_addr",  mem_addr,      32'h0000_0050);
    chk("conc_req",   32'(mem_req),  32'd1);
    chk("conc_ready", 32'(st_ready), 32'd1);
    step();
    chk("conc_hold", mem_addr, 32'h0000_0050);
    ack_step();
    chk("conc_count1", 32'(buf_empty), 32'd1);

    // Misaligned word and halfword, reserved size
`ifdef STORE_MISALIGN_TRAP_EN
    issue(2'b10, 32'h0000_3001, 32'h1122_3344);
    chk("mis_pulse", 32'(st_misalign), 32'd1);
    chk("mis_empty", 32'(buf_empty),   32'd1);
    step();
    chk("mis_clear",  32'(st_misalign), 32'd0);
    chk("mis_empty2", 32'(buf_empty),   32'd1);
    issue(2'b01, 32'h0000_2003, 32'h0000_ABCD);
    chk("mis_half_pulse", 32'(st_misalign), 32'd1);
    issue(2'b11, 32'h0000_4000, 32'h0000_0000);
    chk("mis_rsvd_pulse", 32'(st_misalign), 32'd1);
    chk("mis_rsvd_empty", 32'(buf_empty),   32'd1);
    step();
    chk("mis_rsvd_clear", 32'(st_misalign), 32'd0);
`else
    issue(2'b10, 32'h0000_3001, 32'h1122_3344);
    chk("mis_addr",  mem_addr,         32'h0000_3000);
    chk("mis_be",    32'(mem_be),      32'hF);
    chk("mis_wdata", mem_wdata,        32'h1122_3344);
    chk("mis_flag",  32'(st_misalign), 32'd0);
    ack_step();
    issue(2'b01, 32'h0000_2003, 32'h0000_ABCD);
    chk("mis_half_be",    32'(mem_be), 32'hC);
    chk("mis_half_wdata", mem_wdata,   32'hABCD_ABCD);
    ack_step();
    issue(2'b11, 32'h0000_4002, 32'h5566_7788);
    chk("rsvd_be",    32'(mem_be), 32'hF);
    chk("rsvd_wdata", mem_wdata,   32'h5566_7788);
    chk("rsvd_addr",  mem_addr,    32'h0000_4000);
    ack_step();
`endif
    chk("pre_rst_empty", 32'(buf_empty), 32'd1);

    // Reset with two entries queued
    issue(2'b10, 32'h0000_0060, 32'h0000_0006);
    issue(2'b10, 32'h0000_0070, 32'h0000_0007);
    chk("pre_rst_full", 32'(st_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req",   32'(mem_req),   32'd0);
    chk("midrst_empty", 32'(buf_empty), 32'd1);
    chk("midrst_ready", 32'(st_ready),  32'd1);
    chk("midrst_addr",  mem_addr,       32'h0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_no_req", 32'(mem_req), 32'd0);
    end
    issue(2'b00, 32'h0000_0080, 32'h0000_007F);
    chk("new_addr",  mem_addr,    32'h0000_0080);
    chk("new_be",    32'(mem_be), 32'h1);
    chk("new_wdata", mem_wdata,   32'h7F7F_7F7F);
    ack_step();
    chk("final_empty", 32'(buf_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
